// File: rtl/enc_prio_deb_pkg.sv
// Shared types and helpers for the debounced priority encoder.
package enc_prio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STABLE  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Widest request vector the index helper can scan.
    localparam int MAX_N = 64;

    // Highest set bit among the lowest n bits of d, 0 when none are set.
    function automatic int highest_set(input logic [MAX_N-1:0] d, input int n);
        highest_set = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && d[i]) begin
                highest_set = i;
            end
        end
    endfunction

endpackage

// File: rtl/enc_prio_deb_if.sv
// Request/report bundle between the raw request lines, the encoder and its consumer.
interface enc_prio_deb_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) ();
    logic         E;
    logic [N-1:0] D;
    logic         ACK;
    logic [W-1:0] Y;
    logic         V;
    logic         M;

    modport master (output E, D, ACK, input Y, V, M);
    modport slave  (input E, D, ACK, output Y, V, M);
endinterface

// File: rtl/enc_prio_deb_prio_enc_comb.sv
// Purely combinational priority encoder: index of the highest active line,
// whether any line is active under enable, and whether several are active.
module prio_enc_comb
    import enc_prio_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] d,
    input  logic         e,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         multi
);
    logic [MAX_N-1:0] d_ext;

    assign d_ext = MAX_N'(d);
    assign idx   = W'(highest_set(d_ext, N));
    assign any   = e & (|d);
    assign multi = ($countones(d) > 1);
endmodule

// File: rtl/enc_prio_deb.sv
// Registered priority encoder with debounce and valid/ack handshake.
// A request must hold the same index for DEB+1 edges before it is reported,
// the report is held until acknowledged, and it is not reported again until
// every line has been released.
module enc_prio_deb
    import enc_prio_pkg::*;
#(
    parameter int N   = 8,
    parameter int W   = $clog2(N),
    parameter int DEB = 4
) (
    input logic          clk,
    input logic          rst_n,
    enc_prio_deb_if.slave bus
);
    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    state_t         state, state_next;
    logic [W-1:0]   cand, cand_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [W-1:0]   y, y_next;
    logic           v, v_next;
    logic           m, m_next;

    logic [W-1:0]   idx;
    logic           any;
    logic           multi;

    prio_enc_comb #(.N(N), .W(W)) u_enc (
        .d     (bus.D),
        .e     (bus.E),
        .idx   (idx),
        .any   (any),
        .multi (multi)
    );

    // State, debounce candidate/counter and output registers; reset clears outputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
            y     <= '0;
            v     <= 1'b0;
            m     <= 1'b0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
            y     <= y_next;
            v     <= v_next;
            m     <= m_next;
        end
    end

    // Next-state logic; dropping enable overrides everything, including a pending ACK.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        y_next     = y;
        v_next     = v;
        m_next     = m;

        if (!bus.E) begin
            state_next = IDLE;
            v_next     = 1'b0;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        cand_next  = idx;
                        cnt_next   = '0;
                        state_next = STABLE;
                    end
                end
                STABLE: begin
                    if (!any) begin
                        state_next = IDLE;
                    end else if (idx != cand) begin
                        cand_next = idx;
                        cnt_next  = '0;
                    end else if (cnt < CNT_LAST) begin
                        cnt_next = cnt + 1'b1;
                    end else begin
                        y_next     = cand;
                        m_next     = multi;
                        v_next     = 1'b1;
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.ACK) begin
                        v_next     = 1'b0;
                        state_next = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!any) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.Y = y;
    assign bus.V = v;
    assign bus.M = m;
endmodule

// File: doc/enc_prio_deb.md
# enc_prio_deb

Registered priority encoder with enable, input debounce and valid/ack handshake. It performs the inverse of the enabled 1:2^n index decoders: it takes N request lines and reports the index of the highest active line. A request must be stable for DEB cycles before it is reported. The reported index is held until the consumer acknowledges it, and is not re-reported until all lines are released. It sits between raw request/key lines and the sequential control logic that consumes encoded addresses.

## Interface
- N, default 8: number of request lines, N ≥ 2.
- W, default $clog2(N): index width.
- DEB, default 4: required stable cycles, DEB ≥ 1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- E  in  1  enable; when low, all requests are treated as absent.
- D  in  N  request lines, active-high, asynchronous to the consumer.
- ACK  in  1  consumer acknowledge, sampled only while V=1.
- Y  out  W  encoded index of the highest-numbered active line, registered.
- V  out  1  index valid, registered.
- M  out  1  more than one line was active when Y was captured, registered.

## Operation
- Combinational terms: any = E & |D; idx = highest i with D[i]=1 (0 when none).
- State register: cand (W bits), cnt (enough bits for DEB-1).
- FSM states: IDLE, STABLE, HOLD, RELEASE.
- IDLE:
  - any=1 → cand=idx, cnt=0, go STABLE.
- STABLE:
  - any=0 → IDLE.
  - idx≠cand → cand=idx, cnt=0, stay in STABLE.
  - idx=cand and cnt<DEB-1 → cnt+1.
  - idx=cand and cnt=DEB-1 → Y=cand, M=(popcount(D)>1), V=1, go HOLD.
- HOLD:
  - Y, M and V are frozen; D changes are ignored.
  - ACK=1 → V=0, go RELEASE.
- RELEASE:
  - any=0 → IDLE.
  - Otherwise wait; the held request is never re-reported.
- E=0 in any state: next edge V=0, cnt=0, go IDLE. Y and M keep their last values. If E returns with D still active, the request is debounced and reported again.
- Reset values: state IDLE, Y=0, V=0, M=0, cand=0, cnt=0.

## Timing
- Latency: a request first seen at edge k gives V=1 after edge k+DEB, i.e. DEB+1 edges with a constant idx.
- Glitch handling: any idx change or drop of any restarts the count. A pulse shorter than DEB+1 cycles is never reported.
- V rises for exactly one report per press. It falls on the edge after ACK is sampled high. Minimum V high time is 1 cycle.
- ACK while V=0 has no effect.
- ACK and E=0 in the same cycle: the E=0 rule wins, giving IDLE.
- Reset asserted mid-handshake: V, Y and M clear immediately, without waiting for clk. The first report after reset release needs the full DEB+1 edges.
- Simultaneous lines: the highest index wins and M=1. A change to a lower line while a higher one stays active is invisible.

## Structure
- Package enc_prio_pkg: state enum typedef (IDLE, STABLE, HOLD, RELEASE) and a function returning the highest set index for a given N.
- Sub-module prio_enc_comb (purely combinational): D, E → idx, any, multi.
- Top level: FSM, counter and output registers.

## Test plan
All scenarios use N=8, DEB=4.
- Reset: rst_n=0 asserted mid-HOLD with Y=5 → V=0, Y=0, M=0 before the next clk edge. After release, D=0 → V stays 0.
- Single press: D=0x04, E=1 held → V=1 after the 5th edge, Y=2, M=0. ACK pulsed 1 cycle → V=0 next edge. D held 20 more cycles → no second report. D=0 then D=0x04 → a new report.
- Multiple lines: D=0x90 stable → Y=7, M=1. D=0x01 → Y=0, M=0.
- Bounce: D alternating 0x04/0x00 every 2 cycles for 20 cycles → V never rises. Then D=0x04 stable → V after 5 edges.
- Change during debounce: D=0x04 for 2 cycles, then 0x08 stable → Y=3, with V asserted 5 edges after the change. In HOLD, D changed to 0x80 → Y stays 3.
- Enable: E=0 in HOLD → V=0 next edge. E=1 again with D=0x08 held → Y=3 reported after 5 edges. ACK and E=0 in the same cycle → IDLE, V=0.
